// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use interlock, multi-cycle load bubbles, memory-wait
// freeze and taken-branch flush control for the 5-stage pipeline.
// Optional performance counters are enabled with the macro HAZARD_PERF_CNT_EN;
// without it stall_cycles and flush_count are tied to zero.
module hazard_stall_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ID_EX_memRead,
  input  logic [REG_AW-1:0] ID_EX_regRt,
  input  logic [REG_AW-1:0] IF_ID_regRs,
  input  logic [REG_AW-1:0] IF_ID_regRt,
  input  logic              IF_ID_usesRs,
  input  logic              IF_ID_usesRt,
  input  logic              mem_busy,
  input  logic              branch_taken,
  output logic              ctrl_mux,
  output logic              pcWrite,
  output logic              ifid_writeReg,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              pipe_freeze,
  output logic              stall_active,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } stateT;

  // The hazard cycle itself is the first bubble, so the stall state covers
  // the remaining LOAD_LAT-1 cycles.
  localparam logic [3:0] LAT_INIT = 4'(LOAD_LAT - 1);

  stateT      state;
  stateT      nextState;
  logic [3:0] latCnt;
  logic [3:0] nextLatCnt;
  logic       hazard;

  // Register 0 is hardwired, so a load into it can never create a dependency.
  assign hazard = ID_EX_memRead && (ID_EX_regRt != '0) &&
                  ((IF_ID_usesRs && (ID_EX_regRt == IF_ID_regRs)) ||
                   (IF_ID_usesRt && (ID_EX_regRt == IF_ID_regRt)));

  // State register and bubble down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RUN;
      latCnt <= 4'd0;
    end else begin
      state  <= nextState;
      latCnt <= nextLatCnt;
    end
  end

  // Next state and pipeline controls, priority reset > mem_busy > branch > stall > hazard.
  always_comb begin
    nextState     = state;
    nextLatCnt    = latCnt;
    ctrl_mux      = 1'b0;
    pcWrite       = 1'b0;
    ifid_writeReg = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    pipe_freeze   = 1'b0;
    stall_active  = 1'b0;
    if (reset) begin
      nextState  = RUN;
      nextLatCnt = 4'd0;
    end else begin
      stall_active = (state == LU_STALL);
      if (mem_busy) begin
        pipe_freeze = 1'b1;
        ctrl_mux    = 1'b1;
      end else if (branch_taken) begin
        ifid_flush    = 1'b1;
        idex_flush    = 1'b1;
        pcWrite       = 1'b1;
        ifid_writeReg = 1'b1;
        nextState     = RUN;
        nextLatCnt    = 4'd0;
      end else if (state == LU_STALL) begin
        nextLatCnt = latCnt - 4'd1;
        if (latCnt == 4'd1) begin
          nextState = RUN;
        end
      end else if (hazard) begin
        if (LOAD_LAT > 1) begin
          nextState  = LU_STALL;
          nextLatCnt = LAT_INIT;
        end
      end else begin
        ctrl_mux      = 1'b1;
        pcWrite       = 1'b1;
        ifid_writeReg = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  // Saturating counters of front-end hold cycles and branch flushes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (!pcWrite && (stallCnt != '1)) begin
        stallCnt <= stallCnt + CNT_W'(1);
      end
      if (ifid_flush && (flushCnt != '1)) begin
        flushCnt <= flushCnt + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stallCnt;
  assign flush_count  = flushCnt;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: scoreboard bench running a single-bubble (LOAD_LAT=1)
// and a multi-bubble (LOAD_LAT=3) controller side by side on shared inputs.
module tb_hazard_stall_ctrl;

  localparam int AW = 5;
  localparam int CW = 16;

  typedef struct packed {
    logic          ctrlMux;
    logic          pcWrite;
    logic          ifidWrite;
    logic          ifidFlush;
    logic          idexFlush;
    logic          freeze;
    logic          stallActive;
    logic [CW-1:0] stallCycles;
    logic [CW-1:0] flushCount;
  } expT;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          memRead = 1'b0;
  logic [AW-1:0] exRt = '0;
  logic [AW-1:0] idRs = '0;
  logic [AW-1:0] idRt = '0;
  logic          usesRs = 1'b0;
  logic          usesRt = 1'b0;
  logic          memBusy = 1'b0;
  logic          branch = 1'b0;

  logic          cmA, pwA, iwA, ifA, xfA, pfA, saA;
  logic [CW-1:0] scA, fcA;
  logic          cmB, pwB, iwB, ifB, xfB, pfB, saB;
  logic [CW-1:0] scB, fcB;

  expT expQA[$];
  expT expQB[$];

  int total = 0;
  int bad   = 0;

  int lat[2]      = '{1, 3};
  int pending[2]  = '{0, 0};
  int stallCnt[2] = '{0, 0};
  int flushCnt[2] = '{0, 0};

  hazard_stall_ctrl #(.REG_AW(AW), .LOAD_LAT(1), .CNT_W(CW)) dutA (
    .clk(clk), .reset(reset),
    .ID_EX_memRead(memRead), .ID_EX_regRt(exRt),
    .IF_ID_regRs(idRs), .IF_ID_regRt(idRt),
    .IF_ID_usesRs(usesRs), .IF_ID_usesRt(usesRt),
    .mem_busy(memBusy), .branch_taken(branch),
    .ctrl_mux(cmA), .pcWrite(pwA), .ifid_writeReg(iwA),
    .ifid_flush(ifA), .idex_flush(xfA), .pipe_freeze(pfA),
    .stall_active(saA), .stall_cycles(scA), .flush_count(fcA)
  );

  hazard_stall_ctrl #(.REG_AW(AW), .LOAD_LAT(3), .CNT_W(CW)) dutB (
    .clk(clk), .reset(reset),
    .ID_EX_memRead(memRead), .ID_EX_regRt(exRt),
    .IF_ID_regRs(idRs), .IF_ID_regRt(idRt),
    .IF_ID_usesRs(usesRs), .IF_ID_usesRt(usesRt),
    .mem_busy(memBusy), .branch_taken(branch),
    .ctrl_mux(cmB), .pcWrite(pwB), .ifid_writeReg(iwB),
    .ifid_flush(ifB), .idex_flush(xfB), .pipe_freeze(pfB),
    .stall_active(saB), .stall_cycles(scB), .flush_count(fcB)
  );

  // Free-running pipeline clock.
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic checkOutput(input string who, input expT got, input expT exp);
    cmp({who, ".ctrl_mux"},      int'(got.ctrlMux),     int'(exp.ctrlMux));
    cmp({who, ".pcWrite"},       int'(got.pcWrite),     int'(exp.pcWrite));
    cmp({who, ".ifid_writeReg"}, int'(got.ifidWrite),   int'(exp.ifidWrite));
    cmp({who, ".ifid_flush"},    int'(got.ifidFlush),   int'(exp.ifidFlush));
    cmp({who, ".idex_flush"},    int'(got.idexFlush),   int'(exp.idexFlush));
    cmp({who, ".pipe_freeze"},   int'(got.freeze),      int'(exp.freeze));
    cmp({who, ".stall_active"},  int'(got.stallActive), int'(exp.stallActive));
    cmp({who, ".stall_cycles"},  int'(got.stallCycles), int'(exp.stallCycles));
    cmp({who, ".flush_count"},   int'(got.flushCount),  int'(exp.flushCount));
  endtask

  // Reference model: track how many bubbles are still owed after this cycle.
  function automatic expT modelStep(input int i, input logic rst, input logic hz,
                                    input logic mb, input logic br);
    expT e;
    e = '0;
    if (rst) begin
      pending[i]  = 0;
      stallCnt[i] = 0;
      flushCnt[i] = 0;
      return e;
    end
`ifdef HAZARD_PERF_CNT_EN
    e.stallCycles = CW'(stallCnt[i]);
    e.flushCount  = CW'(flushCnt[i]);
`endif
    e.stallActive = (pending[i] > 0);
    if (mb) begin
      e.freeze  = 1'b1;
      e.ctrlMux = 1'b1;
    end else if (br) begin
      e.ifidFlush = 1'b1;
      e.idexFlush = 1'b1;
      e.pcWrite   = 1'b1;
      e.ifidWrite = 1'b1;
      pending[i]  = 0;
    end else if (pending[i] > 0) begin
      pending[i] = pending[i] - 1;
    end else if (hz) begin
      pending[i] = lat[i] - 1;
    end else begin
      e.ctrlMux   = 1'b1;
      e.pcWrite   = 1'b1;
      e.ifidWrite = 1'b1;
    end
    if (!e.pcWrite && stallCnt[i] < (1 << CW) - 1) stallCnt[i]++;
    if (e.ifidFlush && flushCnt[i] < (1 << CW) - 1) flushCnt[i]++;
    return e;
  endfunction

  task automatic applyStimulus(input logic rst, input logic mr, input logic [AW-1:0] eRt,
                               input logic [AW-1:0] dRs, input logic [AW-1:0] dRt,
                               input logic uRs, input logic uRt,
                               input logic mb, input logic br);
    logic hz;
    @(posedge clk);
    #1;
    reset   = rst;
    memRead = mr;
    exRt    = eRt;
    idRs    = dRs;
    idRt    = dRt;
    usesRs  = uRs;
    usesRt  = uRt;
    memBusy = mb;
    branch  = br;
    hz = mr && (eRt != '0) && ((uRs && eRt == dRs) || (uRt && eRt == dRt));
    expQA.push_back(modelStep(0, rst, hz, mb, br));
    expQB.push_back(modelStep(1, rst, hz, mb, br));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic loadUse();
    applyStimulus(1'b0, 1'b1, 5'd5, 5'd5, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: mid-cycle, compare every presented output set with the oldest expectation.
  always @(negedge clk) begin
    expT e;
    expT g;
    if (expQA.size() > 0) begin
      e = expQA.pop_front();
      g = '{cmA, pwA, iwA, ifA, xfA, pfA, saA, scA, fcA};
      checkOutput("L1", g, e);
    end
    if (expQB.size() > 0) begin
      e = expQB.pop_front();
      g = '{cmB, pwB, iwB, ifB, xfB, pfB, saB, scB, fcB};
      checkOutput("L3", g, e);
    end
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    // Plain load-use on rs, then the bubble clears it.
    loadUse();
    idle(4);
    // Load into $0 and an rt match without usesRt never stall.
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    // Memory wait during the stall.
    loadUse();
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    // Taken branch in the second stall cycle.
    loadUse();
    idle(1);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // Back-to-back hazards.
    loadUse();
    idle(2);
    loadUse();
    idle(3);
    // Reset asserted between edges in the middle of a stall.
    loadUse();
    idle(1);
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    // Randomized traffic with small register numbers so hazards are frequent.
    for (int n = 0; n < 500; n++) begin
      applyStimulus($urandom_range(0, 99) < 2,
                    1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 8);
    end
    idle(2);
    @(posedge clk);
    #1;
    cmp("scoreboard_drained", expQA.size() + expQB.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
